uart_axi_lite: RTL and testbench
================================

UART_AXI_LITE -- requirements
Module: uart_axi_lite

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-002 SHALL have parameter CLK_FREQ, default 100000000, aclk frequency in Hz.
REQ-003 SHALL have port aclk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 SHALL have port aresetn, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have AXI-Lite write ports: s_axi_awaddr in 32, s_axi_awvalid in 1, s_axi_awready out 1, s_axi_wdata in 32, s_axi_wvalid in 1, s_axi_wready out 1, s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1.
REQ-006 SHALL have AXI-Lite read ports: s_axi_araddr in 32, s_axi_arvalid in 1, s_axi_arready out 1, s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1.
REQ-007 SHALL have uart_tx out 1 (serial data out, idle high), uart_rx in 1 (serial data in), uart_rts_n out 1 (low = ready to receive), uart_cts_n in 1 (low = peer may accept), interrupt out 1 (active-high level).

Function
REQ-008 SHALL decode addr[3:2]: 0x0 RXDATA (RO), 0x4 TXDATA (WO), 0x8 STATUS (RO), 0xC CONTROL (R/W); addr[31:4] and addr[1:0] ignored.
REQ-009 SHALL accept a write only when awvalid and wvalid are both high and no B response is pending: awready=wready=1 for that one cycle, bvalid=1 next cycle, held until bready; bresp always 2'b00.
REQ-010 SHALL accept a read when arvalid and no R response pending: arready=1 one cycle, rvalid=1 next cycle with data, held stable until rready; rresp always 2'b00.
REQ-011 RXDATA read SHALL return {24'b0, head byte} and pop the 16-entry RX FIFO; read when empty returns 0, no pop.
REQ-012 TXDATA write SHALL push wdata[7:0] into the 16-entry TX FIFO; write when full is dropped; writes to RXDATA/STATUS ignored.
REQ-013 STATUS bits: [0] RX non-empty, [1] RX full, [2] TX empty, [3] TX full, [4] interrupt enable, [5] overrun, [6] frame error, [7] TX-done flag; others 0.
REQ-014 STATUS read SHALL clear bits [5], [6], [7] after returning them.
REQ-015 CONTROL write: bit0=1 flushes TX FIFO, bit1=1 flushes RX FIFO (self-clearing, read as 0), bit4 = interrupt enable (stored); read returns {27'b0, bit4, 4'b0}.
REQ-016 Bit period SHALL be DIV = round(CLK_FREQ/BAUD_RATE) aclk cycles (868 at defaults); frame 8N1: start 0, 8 data LSB first, stop 1.
REQ-017 TX FSM states IDLE, START, DATA, STOP: IDLE leaves when TX FIFO non-empty (and CTS permits, REQ-023), popping one byte; each state lasts DIV cycles per bit; STOP returns to IDLE and sets TX-done when TX FIFO is then empty.
REQ-018 RX SHALL double-flop synchronise uart_rx; RX FSM IDLE, START, DATA, STOP: falling edge enters START, start re-sampled at DIV/2, high -> back to IDLE (glitch); data bits and stop sampled every DIV from mid-start.
REQ-019 Stop sampled 0 SHALL set frame error and still store the byte; RX FIFO full at stop SHALL drop the byte and set overrun.
REQ-020 interrupt SHALL equal enable & (RX non-empty | TX-done).
REQ-021 Simultaneous FIFO push and pop SHALL both take effect; flush wins over a same-cycle push.

Reset
REQ-022 On aresetn low: all ready/valid outputs 0, bresp/rresp/rdata 0, uart_tx 1, interrupt 0, uart_rts_n 0, FIFOs empty, flags and enable 0, FSMs IDLE; a frame in progress is abandoned.

Configuration
REQ-023 With UART_AXI_LITE_FLOW_CTRL_EN defined: TX starts a new frame only while uart_cts_n=0 (frame in progress completes), and uart_rts_n=1 while RX FIFO holds >=14 bytes, else 0; without it: uart_cts_n ignored, uart_rts_n constant 0.

Verification
REQ-024 Write 0x55 to 0x4 -> uart_tx shows 0,1,0,1,0,1,0,1,0,1 with each bit 868 cycles; STATUS then reads bit2=1, bit7=1.
REQ-025 Loop uart_tx to uart_rx, write 0xA3 -> STATUS bit0=1; read 0x0 returns 0x000000A3; STATUS bit0=0 afterwards.
REQ-026 Set CONTROL=0x10, receive one byte -> interrupt=1; read RXDATA and STATUS -> interrupt=0.
REQ-027 Drive 17 frames into uart_rx without reading -> STATUS bits1 and 5 =1; 16 reads return first 16 bytes in order.
REQ-028 Frame with stop bit 0 -> STATUS bit6=1, cleared on second STATUS read; 4-cycle low glitch on uart_rx -> no byte stored.
REQ-029 Assert aresetn low mid-frame -> uart_tx=1 immediately, STATUS reads 0x00000004 after release.

Source files
------------

// File: rtl/uart_axi_lite.sv
// AXI-Lite UART: 16-byte RX/TX FIFOs, 8N1 framing, status/control registers.
// Optional RTS/CTS flow control is enabled by defining UART_AXI_LITE_FLOW_CTRL_EN.
module uart_axi_lite #(
  parameter int BAUD_RATE = 115200,
  parameter int CLK_FREQ  = 100000000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        uart_rts_n,
  input  logic        uart_cts_n,
  output logic        interrupt
);

  localparam int DIV  = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        int_en_q, int_en_d, overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d, tx_done_q, tx_done_d;

  logic [7:0]  tx_mem_q [16];
  logic [7:0]  tx_mem_d [16];
  logic [3:0]  tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [4:0]  tx_level_q, tx_level_d;
  logic [7:0]  rx_mem_q [16];
  logic [7:0]  rx_mem_d [16];
  logic [3:0]  rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [4:0]  rx_level_q, rx_level_d;

  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_baud_q, tx_baud_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;

  logic          rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;

  logic        wr_accept, rd_accept, cts_ok;
  logic [1:0]  wr_sel, rd_sel;
  logic        tx_push, tx_pop, tx_flush, tx_done_set;
  logic        rx_push, rx_pop, rx_flush, frame_err_set, status_clr;
  logic [31:0] status_word, rd_word;
  logic        unused_bits;

  assign wr_sel    = s_axi_awaddr[3:2];
  assign rd_sel    = s_axi_araddr[3:2];
  assign wr_accept = aresetn & s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
  assign rd_accept = aresetn & s_axi_arvalid & ~rvalid_q;
  assign unused_bits = ^{s_axi_awaddr[31:4], s_axi_awaddr[1:0],
                         s_axi_araddr[31:4], s_axi_araddr[1:0], s_axi_wdata[31:8]};

`ifdef UART_AXI_LITE_FLOW_CTRL_EN
  assign cts_ok     = ~uart_cts_n;
  assign uart_rts_n = (rx_level_q >= 5'd14);
`else
  logic unused_cts;
  assign unused_cts = uart_cts_n;
  assign cts_ok     = 1'b1;
  assign uart_rts_n = 1'b0;
`endif

  assign status_word = {24'b0, tx_done_q, frame_err_q, overrun_q, int_en_q,
                        (tx_level_q == 5'd16), (tx_level_q == 5'd0),
                        (rx_level_q == 5'd16), (rx_level_q != 5'd0)};

  always_comb begin
    rd_word = 32'b0;
    case (rd_sel)
      2'd0: if (rx_level_q != 5'd0) rd_word = {24'b0, rx_mem_q[rx_rptr_q]};
      2'd2: rd_word = status_word;
      2'd3: rd_word = {27'b0, int_en_q, 4'b0};
      default: rd_word = 32'b0;
    endcase
  end

  // Register side effects of accepted accesses; CONTROL flush bits are one-shot.
  always_comb begin
    tx_push    = 1'b0;
    tx_flush   = 1'b0;
    rx_flush   = 1'b0;
    rx_pop     = 1'b0;
    status_clr = 1'b0;
    int_en_d   = int_en_q;
    if (wr_accept) begin
      case (wr_sel)
        2'd1: tx_push = (tx_level_q != 5'd16);
        2'd3: begin
          tx_flush = s_axi_wdata[0];
          rx_flush = s_axi_wdata[1];
          int_en_d = s_axi_wdata[4];
        end
        default: ;
      endcase
    end
    if (rd_accept) begin
      case (rd_sel)
        2'd0: rx_pop = (rx_level_q != 5'd0);
        2'd2: status_clr = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bvalid_d = bvalid_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
    if (wr_accept) bvalid_d = 1'b1;
    if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
    if (rd_accept) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
    end
  end

  // A new event in the same cycle as a STATUS read survives the clear.
  always_comb begin
    tx_done_d   = (tx_done_q & ~status_clr) | tx_done_set;
    frame_err_d = (frame_err_q & ~status_clr) | frame_err_set;
    overrun_d   = (overrun_q & ~status_clr) | (rx_push & (rx_level_q == 5'd16));
  end

  always_comb begin
    tx_mem_d   = tx_mem_q;
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_level_d = tx_level_q;
    if (tx_flush) begin
      tx_wptr_d  = 4'd0;
      tx_rptr_d  = 4'd0;
      tx_level_d = 5'd0;
    end else begin
      if (tx_push) begin
        tx_mem_d[tx_wptr_q] = s_axi_wdata[7:0];
        tx_wptr_d = tx_wptr_q + 4'd1;
      end
      if (tx_pop) tx_rptr_d = tx_rptr_q + 4'd1;
      tx_level_d = tx_level_q + {4'b0, tx_push} - {4'b0, tx_pop};
    end
  end

  always_comb begin
    rx_mem_d   = rx_mem_q;
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    rx_level_d = rx_level_q;
    if (rx_flush) begin
      rx_wptr_d  = 4'd0;
      rx_rptr_d  = 4'd0;
      rx_level_d = 5'd0;
    end else begin
      if (rx_push && (rx_level_q != 5'd16)) begin
        rx_mem_d[rx_wptr_q] = rx_shift_q;
        rx_wptr_d  = rx_wptr_q + 4'd1;
        rx_level_d = rx_level_q + 5'd1 - {4'b0, rx_pop};
      end else begin
        rx_level_d = rx_level_q - {4'b0, rx_pop};
      end
      if (rx_pop) rx_rptr_d = rx_rptr_q + 4'd1;
    end
  end

  // Back-to-back frames chain straight from STOP into START without an idle cycle.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_baud_d   = tx_baud_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_line_d   = tx_line_q;
    tx_pop      = 1'b0;
    tx_done_set = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        tx_line_d = 1'b1;
        if ((tx_level_q != 5'd0) && cts_ok) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem_q[tx_rptr_q];
          tx_baud_d  = '0;
          tx_line_d  = 1'b0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_baud_q == DIV_LAST) begin
          tx_baud_d  = '0;
          tx_bit_d   = 3'd0;
          tx_line_d  = tx_shift_q[0];
          tx_state_d = ST_DATA;
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_baud_q == DIV_LAST) begin
          tx_baud_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = ST_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_line_d  = tx_shift_q[1];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
      default: begin
        if (tx_baud_q == DIV_LAST) begin
          tx_baud_d = '0;
          if ((tx_level_q != 5'd0) && cts_ok) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_mem_q[tx_rptr_q];
            tx_line_d  = 1'b0;
            tx_state_d = ST_START;
          end else begin
            tx_state_d  = ST_IDLE;
            tx_done_set = (tx_level_q == 5'd0);
          end
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
    endcase
  end

  // Receiver samples mid-bit: half a period into START, then every full period.
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_baud_d     = rx_baud_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_push       = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_sync2_q) begin
          rx_baud_d  = '0;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d  = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync2_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_baud_q == DIV_LAST) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      default: begin
        if (rx_baud_q == DIV_LAST) begin
          rx_baud_d     = '0;
          rx_push       = 1'b1;
          frame_err_set = ~rx_sync2_q;
          rx_state_d    = ST_IDLE;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'b0;
      int_en_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_done_q   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        tx_mem_q[i] <= 8'b0;
        rx_mem_q[i] <= 8'b0;
      end
      tx_wptr_q   <= 4'd0;
      tx_rptr_q   <= 4'd0;
      tx_level_q  <= 5'd0;
      rx_wptr_q   <= 4'd0;
      rx_rptr_q   <= 4'd0;
      rx_level_q  <= 5'd0;
      tx_state_q  <= ST_IDLE;
      tx_baud_q   <= '0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'b0;
      tx_line_q   <= 1'b1;
      rx_sync1_q  <= 1'b1;
      rx_sync2_q  <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= ST_IDLE;
      rx_baud_q   <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'b0;
    end else begin
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      int_en_q    <= int_en_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      tx_done_q   <= tx_done_d;
      tx_mem_q    <= tx_mem_d;
      rx_mem_q    <= rx_mem_d;
      tx_wptr_q   <= tx_wptr_d;
      tx_rptr_q   <= tx_rptr_d;
      tx_level_q  <= tx_level_d;
      rx_wptr_q   <= rx_wptr_d;
      rx_rptr_q   <= rx_rptr_d;
      rx_level_q  <= rx_level_d;
      tx_state_q  <= tx_state_d;
      tx_baud_q   <= tx_baud_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_line_q   <= tx_line_d;
      rx_sync1_q  <= uart_rx;
      rx_sync2_q  <= rx_sync1_q;
      rx_prev_q   <= rx_sync2_q;
      rx_state_q  <= rx_state_d;
      rx_baud_q   <= rx_baud_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
    end
  end

  assign s_axi_awready = wr_accept;
  assign s_axi_wready  = wr_accept;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = rd_accept;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rvalid  = rvalid_q;
  assign uart_tx       = tx_line_q;
  assign interrupt     = int_en_q & ((rx_level_q != 5'd0) | tx_done_q);

endmodule

// File: tb/tb_uart_axi_lite.sv
// Self-checking bench for uart_axi_lite: register vectors from a table plus
// serial sequences; received bytes are tracked in a scoreboard queue.
module tb_uart_axi_lite;

  localparam int CLK_FREQ  = 16000000;
  localparam int BAUD_RATE = 1000000;
  localparam int DIV       = 16;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic        uart_tx, uart_rx, uart_rts_n, uart_cts_n, interrupt;
  logic        rx_drv, loopback;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expect_data;
    string       tag;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  rx_exp_q[$];

  always #5 clk = ~clk;

  assign uart_rx = loopback ? uart_tx : rx_drv;

  uart_axi_lite #(.BAUD_RATE(BAUD_RATE), .CLK_FREQ(CLK_FREQ)) dut (
    .aclk(clk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .uart_tx(uart_tx), .uart_rx(uart_rx), .uart_rts_n(uart_rts_n), .uart_cts_n(uart_cts_n),
    .interrupt(interrupt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: no response, required within 50 cycles", name);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data);
    int n;
    @(posedge clk); #1;
    s_axi_awaddr = addr; s_axi_wdata = data;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(s_axi_awready && s_axi_wready) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeoutFail("aw_handshake");
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeoutFail("bvalid");
    else if (s_axi_bresp !== 2'b00) checkOutput("bresp", 32'(s_axi_bresp), 32'h0);
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic axiRead(input logic [31:0] addr, output logic [31:0] data);
    int n;
    data = 32'hDEADBEEF;
    @(posedge clk); #1;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeoutFail("ar_handshake");
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_axi_rvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeoutFail("rvalid");
    else begin
      data = s_axi_rdata;
      if (s_axi_rresp !== 2'b00) checkOutput("rresp", 32'(s_axi_rresp), 32'h0);
    end
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
  endtask

  task automatic readExpect(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    axiRead(addr, d);
    checkOutput(tag, d, exp);
  endtask

  task automatic readRx(input string tag);
    logic [31:0] d;
    axiRead(32'h0, d);
    if (rx_exp_q.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL %s: got 0x%08h, required nothing queued", tag, d);
    end else begin
      checkOutput(tag, d, {24'b0, rx_exp_q.pop_front()});
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.is_write) axiWrite(v.addr, v.wdata);
    else readExpect(v.addr, v.expect_data, v.tag);
  endtask

  task automatic addVec(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] e, input string t);
    vec_t v;
    v.is_write = w; v.addr = a; v.wdata = d; v.expect_data = e; v.tag = t;
    vecs.push_back(v);
  endtask

  task automatic driveBit(input logic b);
    rx_drv = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stop);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
    driveBit(stop);
    rx_drv = 1'b1;
  endtask

  // Watches one 0x55 frame on uart_tx; every bit toggles, so each run must be DIV long.
  task automatic txMonitor55();
    int n;
    int len;
    logic lvl;
    n = 0;
    @(negedge clk);
    while (uart_tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      timeoutFail("tx_start_bit");
      return;
    end
    lvl = 1'b0;
    for (int b = 0; b < 9; b++) begin
      len = 0;
      do begin @(negedge clk); len++; end while (uart_tx === lvl && len < 4 * DIV);
      checkOutput($sformatf("tx_run%0d_len", b), len, DIV);
      lvl = ~lvl;
    end
    checkOutput("tx_stop_level", 32'(uart_tx), 32'h1);
    repeat (DIV - 1) @(negedge clk);
    checkOutput("tx_stop_hold", 32'(uart_tx), 32'h1);
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    aresetn = 1'b0;
    s_axi_awaddr = 32'h0; s_axi_wdata = 32'h0; s_axi_araddr = 32'h0;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    uart_cts_n = 1'b0; rx_drv = 1'b1; loopback = 1'b0;

    // Reset state, with requests held high to show the ready outputs stay low.
    waitCycles(3);
    checkOutput("rst_awready", 32'(s_axi_awready), 32'h0);
    checkOutput("rst_arready", 32'(s_axi_arready), 32'h0);
    checkOutput("rst_bvalid", 32'(s_axi_bvalid), 32'h0);
    checkOutput("rst_rvalid", 32'(s_axi_rvalid), 32'h0);
    checkOutput("rst_rdata", s_axi_rdata, 32'h0);
    checkOutput("rst_uart_tx", 32'(uart_tx), 32'h1);
    checkOutput("rst_rts_n", 32'(uart_rts_n), 32'h0);
    checkOutput("rst_interrupt", 32'(interrupt), 32'h0);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    waitCycles(2);

    addVec(1'b0, 32'h8, 32'h0, 32'h04, "status_reset");
    addVec(1'b0, 32'hC, 32'h0, 32'h00, "control_reset");
    addVec(1'b0, 32'h0, 32'h0, 32'h00, "rxdata_empty");
    addVec(1'b0, 32'h4, 32'h0, 32'h00, "txdata_readback");
    addVec(1'b1, 32'hC, 32'h13, 32'h0, "");
    addVec(1'b0, 32'hC, 32'h0, 32'h10, "control_ie");
    addVec(1'b0, 32'h8, 32'h0, 32'h14, "status_ie");
    addVec(1'b1, 32'h8, 32'hFF, 32'h0, "");
    addVec(1'b1, 32'h0, 32'hAA, 32'h0, "");
    addVec(1'b0, 32'hFFFFFFF8, 32'h0, 32'h14, "status_alias");
    addVec(1'b0, 32'h0000000F, 32'h0, 32'h10, "control_lowbits");
    addVec(1'b0, 32'h0, 32'h0, 32'h00, "rxdata_after_write");
    addVec(1'b1, 32'hC, 32'h0, 32'h0, "");
    addVec(1'b0, 32'h8, 32'h0, 32'h04, "status_ie_off");
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Transmit 0x55 and time every bit on the wire.
    fork
      axiWrite(32'h4, 32'h55);
      txMonitor55();
    join
    waitCycles(4);
    readExpect(32'h8, 32'h84, "status_tx_done");
    readExpect(32'h8, 32'h04, "status_tx_done_cleared");

    // Fill the TX FIFO behind a frame in flight, then flush it.
    for (int i = 0; i < 18; i++) axiWrite(32'h4, 32'(i + 1));
    readExpect(32'h8, 32'h08, "status_tx_full");
    axiWrite(32'hC, 32'h01);
    readExpect(32'h8, 32'h04, "status_tx_flushed");
    waitCycles(12 * DIV);
    readExpect(32'h8, 32'h84, "status_inflight_done");
    readExpect(32'h8, 32'h04, "status_inflight_cleared");

    // Loopback of a single byte.
    loopback = 1'b1;
    axiWrite(32'h4, 32'hA3);
    rx_exp_q.push_back(8'hA3);
    waitCycles(11 * DIV + 10);
    readExpect(32'h8, 32'h85, "status_loop_rx");
    readRx("rxdata_loop");
    readExpect(32'h8, 32'h04, "status_loop_after");
    loopback = 1'b0;
    waitCycles(2);

    // Interrupt from a received byte.
    axiWrite(32'hC, 32'h10);
    checkOutput("irq_idle", 32'(interrupt), 32'h0);
    rx_exp_q.push_back(8'h3C);
    sendFrame(8'h3C, 1'b1);
    waitCycles(4);
    checkOutput("irq_rx", 32'(interrupt), 32'h1);
    readRx("rxdata_irq");
    readExpect(32'h8, 32'h14, "status_irq");
    checkOutput("irq_cleared", 32'(interrupt), 32'h0);
    axiWrite(32'hC, 32'h00);

    // Seventeen frames with no reads: the last one overruns.
    for (int i = 0; i < 17; i++) begin
      if (i < 16) rx_exp_q.push_back(8'(i * 13 + 5));
      sendFrame(8'(i * 13 + 5), 1'b1);
    end
    waitCycles(4);
    readExpect(32'h8, 32'h27, "status_overrun");
    for (int i = 0; i < 16; i++) readRx($sformatf("rxdata_fifo%0d", i));
    readExpect(32'h8, 32'h04, "status_drained");

    // Stop bit low, then a short glitch.
    rx_exp_q.push_back(8'h5A);
    sendFrame(8'h5A, 1'b0);
    waitCycles(4);
    readExpect(32'h8, 32'h45, "status_frame_err");
    readExpect(32'h8, 32'h05, "status_frame_err_cleared");
    readRx("rxdata_frame_err");
    rx_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_drv = 1'b1;
    waitCycles(3 * DIV);
    readExpect(32'h8, 32'h04, "status_glitch");

    // Reset in the middle of an outgoing frame.
    axiWrite(32'hC, 32'h10);
    axiWrite(32'h4, 32'h00);
    waitCycles(3 * DIV);
    checkOutput("tx_midframe_low", 32'(uart_tx), 32'h0);
    aresetn = 1'b0;
    #1;
    checkOutput("tx_reset_high", 32'(uart_tx), 32'h1);
    checkOutput("irq_reset", 32'(interrupt), 32'h0);
    waitCycles(2);
    @(negedge clk);
    aresetn = 1'b1;
    waitCycles(2);
    checkOutput("tx_after_reset", 32'(uart_tx), 32'h1);
    readExpect(32'h8, 32'h04, "status_after_reset");
    readExpect(32'hC, 32'h00, "control_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
